data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//   Word-addressed data-memory responder: the slave end of the CPU data-memory port.
//   Accepts one load/store request at a time over a valid/ready handshake.
//   Returns a response after a programmable number of wait cycles.
//   Sits between a multi-cycle/pipelined CPU core's memory stage and on-chip RAM.
//   Replaces the zero-latency data memory so cores can be exercised against wait states.
// PARAMETERS
//   DEPTH     128  number of 32-bit words held (byte address range 0 .. 4*DEPTH-1)
//   LATENCY   2    cycles from request acceptance to response valid; legal range 1..15
// PORTS
//   clk_i          input   1   clock, all state changes on rising edge
//   rst_n          input   1   asynchronous active-low reset
//   req_valid_i    input   1   request present
//   req_ready_o    output  1   responder can accept a request this cycle
//   req_write_i    input   1   1 = store, 0 = load
//   req_addr_i     input   32  byte address
//   req_wdata_i    input   32  store data
//   resp_valid_o   output  1   response present
//   resp_ready_i   input   1   requester consumes response this cycle
//   resp_rdata_o   output  32  load data (0 for stores and errors)
//   resp_err_o     output  1   request was misaligned or out of range
// BEHAVIOUR
//   Reset (async assert, sync-free deassert): state=IDLE, wait counter=0, all memory words=0.
//     Outputs on reset: req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0.
//   FSM states:
//     IDLE: req_ready_o=1.
//       Accept on req_valid_i & req_ready_o at a rising edge.
//       On accept: cnt <= LATENCY-1, next state = (LATENCY==1) ? RESP : WAIT.
//     WAIT: req_ready_o=0, cnt decrements each cycle; at cnt==1 next state = RESP.
//     RESP: resp_valid_o=1, req_ready_o=0.
//       Holds resp_rdata_o/resp_err_o stable until resp_ready_i is sampled high.
//       Then goes to IDLE.
//   Timing: request accepted at edge T => resp_valid_o high from edge T+LATENCY.
//     It stays high until the edge where resp_ready_i=1.
//   At most one outstanding request; no new acceptance in the RESP cycle.
//     Peak throughput is one request per LATENCY+1 cycles.
//   Request fields are sampled only at the accept edge.
//     Later changes on req_* are ignored until the next IDLE.
//   Error rule: err = (addr[1:0]!=0) | (addr[31:2] >= DEPTH).
//     The error flag is latched at accept.
//   Store, no error: mem[addr[31:2]] <= wdata at the accept edge. Response has rdata=0, err=0.
//   Load, no error: mem[addr[31:2]] is captured at the accept edge into the response register.
//   Error case: memory is untouched; response has rdata=0, err=1.
//   Store-then-load to the same word returns the stored value, since the store commits before the next accept.
//   resp_ready_i outside RESP: ignored.
//   req_valid_i outside IDLE: ignored, no queuing.
//   Reset mid-WAIT or mid-RESP: the transaction is dropped and no response is issued.
//     A store already committed at its accept edge is then cleared by the memory reset.
//   No X on any output after reset; resp_rdata_o=0 whenever resp_valid_o=0.
// TESTING
//   1 Reset, then load addr 0x0 -> resp_valid_o at accept+2, rdata=0, err=0; req_ready_o=1 while idle.
//   2 Store 0xDEADBEEF @0x10, then load @0x10 -> load rdata=0xDEADBEEF, err=0.
//     Each resp_valid_o appears exactly 2 cycles after its accept.
//   3 Hold resp_ready_i=0 for 5 cycles in RESP -> resp_valid_o and rdata stay stable.
//     req_ready_o=0 throughout; a req_valid_i pulse in that window is not accepted.
//   4 Load @0x13 and store @0x200 (DEPTH=128) -> both return err=1, rdata=0.
//     Word 0x80>>2 is unchanged and no array write occurs.
//   5 LATENCY=1 build: back-to-back store/load with resp_ready_i tied 1 -> response 1 cycle after each accept.
//     Accepts are spaced 2 cycles apart.
//   6 Assert rst_n low during WAIT -> outputs return to reset values immediately (async).
//     No response after release; a subsequent load of any word returns 0.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if
//   Request/response bundle between a CPU data-memory stage (master) and the
//   data-memory responder (slave).
//
//   Handshake rules (both channels):
//     - A request transfers on a rising edge where req_valid_i and req_ready_o
//       are both high; req_write_i/req_addr_i/req_wdata_i are sampled only then.
//     - A response is offered while resp_valid_o is high. resp_rdata_o and
//       resp_err_o stay stable until the rising edge where resp_ready_i is
//       high, which consumes the response.
//     - resp_ready_i is ignored while no response is offered. req_valid_i is
//       ignored while req_ready_o is low; nothing is queued.
//
//   Signals
//     req_valid_i   master->slave  request present
//     req_ready_o   slave->master  responder can accept this cycle
//     req_write_i   master->slave  1 = store, 0 = load
//     req_addr_i    master->slave  byte address
//     req_wdata_i   master->slave  store data
//     resp_valid_o  slave->master  response present
//     resp_ready_i  master->slave  requester consumes response this cycle
//     resp_rdata_o  slave->master  load data (0 for stores and errors)
//     resp_err_o    slave->master  misaligned or out-of-range request
interface data_mem_responder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Word-addressed data memory with a programmable response latency. Accepts
//   one load/store at a time and answers LATENCY cycles after acceptance.
//
//   Parameters
//     DEPTH    number of 32-bit words (byte range 0 .. 4*DEPTH-1)
//     LATENCY  accept-to-response latency in cycles, 1..15
//
//   Ports
//     clk_i      clock, rising edge
//     rst_n      asynchronous active-low reset; clears FSM and all memory words
//     bus        slave side of data_mem_responder_if
//     dbg_state  current FSM state (0 = IDLE, 1 = WAIT, 2 = RESP)
module data_mem_responder #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  data_mem_responder_if.slave  bus,
  output logic [1:0]           dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          req_err;
  logic [AW-1:0] idx;

  assign accept = bus.req_valid_i && (state == IDLE);
  assign idx    = bus.req_addr_i[AW+1:2];

  // Misaligned, or word index beyond the array.
  assign req_err = (bus.req_addr_i[1:0] != 2'b00) ||
                   ({2'b00, bus.req_addr_i[31:2]} >= 32'(DEPTH));

  // State register and wait counter.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= 4'(LATENCY - 1);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (LATENCY == 1) ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt == 4'd1) state_nxt = RESP;
      end
      RESP: begin
        if (bus.resp_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs. Response fields are gated so they read 0 whenever no response
  // is offered, regardless of what the holding registers contain.
  always_comb begin
    bus.req_ready_o  = (state == IDLE);
    bus.resp_valid_o = (state == RESP);
    bus.resp_rdata_o = (state == RESP) ? rdata_q : 32'd0;
    bus.resp_err_o   = (state == RESP) ? err_q : 1'b0;
    dbg_state        = state;
  end

  // Response holding registers: captured at the accept edge only, so later
  // activity on the request lines cannot disturb a pending response.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      err_q   <= req_err;
      rdata_q <= (!bus.req_write_i && !req_err) ? mem[idx] : 32'd0;
    end
  end

  // Storage. Stores commit at the accept edge, so a load accepted afterwards
  // always observes them. Erroneous requests never touch the array.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (accept && bus.req_write_i && !req_err) begin
      mem[idx] <= bus.req_wdata_i;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int DEPTH = 128;
  localparam int LAT   = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  data_mem_responder_if bus2 ();
  data_mem_responder_if bus1 ();
  logic [1:0] dbg2, dbg1;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_n(rst_n), .bus(bus2.slave), .dbg_state(dbg2)
  );

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut_l1 (
    .clk_i(clk), .rst_n(rst_n), .bus(bus1.slave), .dbg_state(dbg1)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];          // {err, rdata}
  logic [31:0] ref_mem [DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void ref_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endfunction

  // Behavioural memory: word-addressed array, errors never touch it.
  function automatic logic [32:0] ref_txn(input logic wr, input logic [31:0] addr,
                                          input logic [31:0] wdata);
    logic bad;
    int unsigned w;
    w   = addr / 4;
    bad = (addr % 4 != 0) || (w >= DEPTH);
    if (bad) return {1'b1, 32'd0};
    if (wr) begin
      ref_mem[w] = wdata;
      return {1'b0, 32'd0};
    end
    return {1'b0, ref_mem[w]};
  endfunction

  // ---------------- driver ----------------
  // One full transaction on the LATENCY=2 instance. hold = cycles with
  // resp_ready low in RESP; pulse = fire a stray store while waiting there.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, input bit pulse);
    logic [32:0] e;
    int lat;
    int k;
    e = ref_txn(wr, addr, wdata);
    exp_q.push_back(e);

    @(negedge clk);
    bus2.req_valid_i = 1'b1;
    bus2.req_write_i = wr;
    bus2.req_addr_i  = addr;
    bus2.req_wdata_i = wdata;
    k = 0;
    while (!bus2.req_ready_o && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("req_ready_before_accept", {31'd0, bus2.req_ready_o}, 32'd1);
    @(posedge clk);                      // accept edge

    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        bus2.req_valid_i = 1'b0;
        bus2.req_addr_i  = $urandom;     // must be ignored
        bus2.req_wdata_i = $urandom;
      end
      if (bus2.resp_valid_o) break;
      check("req_ready_in_wait", {31'd0, bus2.req_ready_o}, 32'd0);
    end
    check("latency", lat, LAT);

    e = exp_q.pop_front();
    check("resp_rdata", bus2.resp_rdata_o, e[31:0]);
    check("resp_err", {31'd0, bus2.resp_err_o}, {31'd0, e[32]});

    for (int i = 0; i < hold; i++) begin
      if (pulse && i == 1) begin
        bus2.req_valid_i = 1'b1;
        bus2.req_write_i = 1'b1;
        bus2.req_addr_i  = 32'h20;
        bus2.req_wdata_i = 32'h55AA_55AA;
      end
      if (pulse && i == 2) bus2.req_valid_i = 1'b0;
      @(negedge clk);
      check("hold_valid", {31'd0, bus2.resp_valid_o}, 32'd1);
      check("hold_rdata", bus2.resp_rdata_o, e[31:0]);
      check("hold_err", {31'd0, bus2.resp_err_o}, {31'd0, e[32]});
      check("hold_req_ready", {31'd0, bus2.req_ready_o}, 32'd0);
    end
    bus2.req_valid_i = 1'b0;

    bus2.resp_ready_i = 1'b1;
    @(negedge clk);
    bus2.resp_ready_i = 1'b0;
    check("after_consume_valid", {31'd0, bus2.resp_valid_o}, 32'd0);
    check("after_consume_ready", {31'd0, bus2.req_ready_o}, 32'd1);
    check("after_consume_rdata", bus2.resp_rdata_o, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    logic [31:0] v;
    int sel;

    bus2.req_valid_i = 0; bus2.req_write_i = 0; bus2.req_addr_i = 0;
    bus2.req_wdata_i = 0; bus2.resp_ready_i = 0;
    bus1.req_valid_i = 0; bus1.req_write_i = 0; bus1.req_addr_i = 0;
    bus1.req_wdata_i = 0; bus1.resp_ready_i = 1;
    ref_clear();

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset values.
    check("rst_req_ready", {31'd0, bus2.req_ready_o}, 32'd1);
    check("rst_resp_valid", {31'd0, bus2.resp_valid_o}, 32'd0);
    check("rst_rdata", bus2.resp_rdata_o, 32'd0);
    check("rst_err", {31'd0, bus2.resp_err_o}, 32'd0);

    // Load from a freshly reset word, then store/load round trip.
    do_txn(1'b0, 32'h0, 32'h0, 0, 1'b0);
    do_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 0, 1'b0);
    do_txn(1'b0, 32'h10, 32'h0, 0, 1'b0);

    // Backpressure in RESP with a stray request; the stray store must not land.
    do_txn(1'b0, 32'h10, 32'h0, 5, 1'b1);
    do_txn(1'b0, 32'h20, 32'h0, 0, 1'b0);

    // Error cases, then confirm word 0x80 untouched.
    do_txn(1'b1, 32'h80, 32'h1234_5678, 0, 1'b0);
    do_txn(1'b0, 32'h13, 32'h0, 0, 1'b0);
    do_txn(1'b1, 32'h200, 32'hFFFF_FFFF, 0, 1'b0);
    do_txn(1'b0, 32'h80, 32'h0, 0, 1'b0);
    do_txn(1'b0, 32'h1FC, 32'h0, 0, 1'b0);   // last valid word

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5)      a = 32'($urandom_range(0, 15)) * 4;
      else if (sel == 6) a = 32'($urandom_range(0, DEPTH - 1)) * 4;
      else if (sel == 7) a = (32'($urandom_range(0, DEPTH - 1)) * 4) | 32'($urandom_range(1, 3));
      else if (sel == 8) a = 32'($urandom_range(DEPTH, 4000)) * 4;
      else               a = $urandom;
      v = $urandom;
      do_txn(1'($urandom_range(0, 1)), a, v, $urandom_range(0, 3), 1'b0);
    end

    // LATENCY=1 instance, resp_ready tied high, request held back-to-back.
    @(negedge clk);
    check("l1_ready_idle", {31'd0, bus1.req_ready_o}, 32'd1);
    bus1.req_valid_i = 1'b1;
    bus1.req_write_i = 1'b1;
    bus1.req_addr_i  = 32'h4;
    bus1.req_wdata_i = 32'hCAFE_F00D;
    @(negedge clk);                       // store accepted at previous edge
    check("l1_store_valid", {31'd0, bus1.resp_valid_o}, 32'd1);
    check("l1_store_rdata", bus1.resp_rdata_o, 32'd0);
    check("l1_store_err", {31'd0, bus1.resp_err_o}, 32'd0);
    check("l1_resp_ready_low", {31'd0, bus1.req_ready_o}, 32'd0);
    bus1.req_write_i = 1'b0;
    @(negedge clk);                       // response consumed, not yet accepted
    check("l1_gap_valid", {31'd0, bus1.resp_valid_o}, 32'd0);
    check("l1_gap_ready", {31'd0, bus1.req_ready_o}, 32'd1);
    @(negedge clk);                       // load accepted two cycles after store
    check("l1_load_valid", {31'd0, bus1.resp_valid_o}, 32'd1);
    check("l1_load_rdata", bus1.resp_rdata_o, 32'hCAFE_F00D);
    bus1.req_valid_i = 1'b0;
    @(negedge clk);

    // Asynchronous reset while a load is in WAIT.
    do_txn(1'b1, 32'h40, 32'hA5A5_0001, 0, 1'b0);
    @(negedge clk);
    bus2.req_valid_i = 1'b1;
    bus2.req_write_i = 1'b0;
    bus2.req_addr_i  = 32'h40;
    @(negedge clk);                       // accepted; now in WAIT
    bus2.req_valid_i = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_ready", {31'd0, bus2.req_ready_o}, 32'd1);
    check("async_rst_valid", {31'd0, bus2.resp_valid_o}, 32'd0);
    check("async_rst_rdata", bus2.resp_rdata_o, 32'd0);
    check("async_rst_err", {31'd0, bus2.resp_err_o}, 32'd0);
    ref_clear();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_resp_after_rst", {31'd0, bus2.resp_valid_o}, 32'd0);
    end
    do_txn(1'b0, 32'h40, 32'h0, 0, 1'b0);
    do_txn(1'b0, 32'h10, 32'h0, 0, 1'b0);

    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
